// File: rtl/ram_latency_model.sv
// Behavioural single-port main memory with a programmable BUSY window before
// each one-cycle ACCESS, plus a side preload/dump port for the bench.

package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

module ram_latency_model #(
    parameter int unsigned LAT    = 2,   // BUSY cycles before ACCESS, 1..15
    parameter int unsigned ADDR_W = 14   // word-index width
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      ramREN,
    input  logic                      ramWEN,
    input  logic [31:0]               ramaddr,
    input  logic [31:0]               ramstore,
    output logic [31:0]               ramload,
    output cpu_types_pkg::ramstate_t  ramstate,
    input  logic                      ldWEN,
    input  logic [ADDR_W-1:0]         ldaddr,
    input  logic [31:0]               lddata,
    output logic [31:0]               lddata_out
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    // Key layout: {ren, wen, ramaddr[31:2], ramstore}
    localparam int unsigned KEY_W   = 2 + 30 + DATA_W;
    localparam int unsigned KEY_REN = KEY_W - 1;
    localparam int unsigned KEY_WEN = KEY_W - 2;
    localparam int unsigned KEY_ADR = DATA_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACC  = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [KEY_W-1:0]    r_key;
    logic [KEY_W-1:0]    w_key_live;
    logic                w_latch;
    logic [DATA_W-1:0]   r_ramload;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_req;
    logic                w_in_range;
    logic                w_legal;
    logic                w_illegal;
    logic                w_ld_ok;
    logic [ADDR_W-1:0]   w_acc_idx;
    logic                w_unused;

    assign w_key_live = {ramREN, ramWEN, ramaddr[31:2], ramstore};
    assign w_req      = ramREN | ramWEN;
    assign w_in_range = (ramaddr[31:ADDR_W+2] == '0);
    assign w_legal    = (ramREN ^ ramWEN) & w_in_range;
    assign w_illegal  = w_req & ~w_legal;
    assign w_ld_ok    = (r_state == S_IDLE) & ~w_req;
    assign w_acc_idx  = r_key[KEY_ADR +: ADDR_W];
    assign w_unused   = ^{ramaddr[1:0]};

    assign ramload    = r_ramload;
    assign lddata_out = r_mem[ldaddr];

    // State, countdown and latched request key.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_key   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_latch) begin
                r_key <= w_key_live;
            end
        end
    end

    // Next-state: latch on entry to WAIT, restart on any key change, abort on drop.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_latch    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_legal) begin
                    w_next     = S_WAIT;
                    w_cnt_next = CNT_W'(LAT - 1);
                    w_latch    = 1'b1;
                end else if (w_illegal) begin
                    w_next = S_ERR;
                end
            end
            S_WAIT: begin
                if (!w_req) begin
                    w_next = S_IDLE;
                end else if (w_key_live != r_key) begin
                    // A change to an illegal request is reported rather than served.
                    if (w_legal) begin
                        w_cnt_next = CNT_W'(LAT - 1);
                        w_latch    = 1'b1;
                    end else begin
                        w_next = S_ERR;
                    end
                end else if (r_cnt == '0) begin
                    w_next = S_ACC;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_ACC: begin
                w_next = S_IDLE;
            end
            S_ERR: begin
                if (!w_illegal) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Handshake status decoded straight from the state register.
    always_comb begin
        ramstate = cpu_types_pkg::FREE;
        case (r_state)
            S_IDLE:  ramstate = cpu_types_pkg::FREE;
            S_WAIT:  ramstate = cpu_types_pkg::BUSY;
            S_ACC:   ramstate = cpu_types_pkg::ACCESS;
            S_ERR:   ramstate = cpu_types_pkg::ERROR;
            default: ramstate = cpu_types_pkg::FREE;
        endcase
    end

    // Read data is loaded on entry to ACC and is zero in every other cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ramload <= '0;
        end else if ((w_next == S_ACC) && r_key[KEY_REN]) begin
            r_ramload <= r_mem[w_acc_idx];
        end else begin
            r_ramload <= '0;
        end
    end

    // Memory array: request write commits at the end of ACC; preload only when idle.
    always_ff @(posedge CLK) begin
        if ((r_state == S_ACC) && r_key[KEY_WEN]) begin
            r_mem[w_acc_idx] <= r_key[DATA_W-1:0];
        end else if (ldWEN && w_ld_ok) begin
            r_mem[ldaddr] <= lddata;
        end
    end

`ifndef SYNTHESIS
    // Flag preload strobes that arrive while the RAM is busy; they are dropped.
    always_ff @(posedge CLK) begin
        if (nRST && ldWEN && !w_ld_ok) begin
            $error("ram_latency_model: preload to 0x%0h dropped, RAM not idle", ldaddr);
        end
    end
`endif

endmodule

// File: tb/tb_ram_latency_model.sv
// Directed bench for ram_latency_model: latency window, write/read, restart,
// error handling and asynchronous reset during a pending write.

module tb_ram_latency_model;

    localparam int unsigned LAT    = 2;
    localparam int unsigned ADDR_W = 14;

    localparam logic [31:0] ST_FREE   = 32'd0;
    localparam logic [31:0] ST_BUSY   = 32'd1;
    localparam logic [31:0] ST_ACCESS = 32'd2;
    localparam logic [31:0] ST_ERROR  = 32'd3;

    logic              CLK;
    logic              nRST;
    logic              ramREN;
    logic              ramWEN;
    logic [31:0]       ramaddr;
    logic [31:0]       ramstore;
    logic [31:0]       ramload;
    logic [1:0]        ramstate;
    logic              ldWEN;
    logic [ADDR_W-1:0] ldaddr;
    logic [31:0]       lddata;
    logic [31:0]       lddata_out;

    int n_checks;
    int n_pass;

    ram_latency_model #(.LAT(LAT), .ADDR_W(ADDR_W)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .ramREN     (ramREN),
        .ramWEN     (ramWEN),
        .ramaddr    (ramaddr),
        .ramstore   (ramstore),
        .ramload    (ramload),
        .ramstate   (ramstate),
        .ldWEN      (ldWEN),
        .ldaddr     (ldaddr),
        .lddata     (lddata),
        .lddata_out (lddata_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        ldWEN  = 1'b1;
        ldaddr = a;
        lddata = d;
        @(negedge CLK);
        ldWEN  = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        ldaddr = a;
        #1;
        check(tag, lddata_out, exp);
    endtask

    // Starts at a negedge with the RAM idle; ends at the ACCESS negedge (drop=0)
    // or at the following FREE negedge with the request released (drop=1).
    task automatic run_req(input string tag, input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] store,
                           input bit chk_load, input logic [31:0] exp_load, input bit drop);
        ramREN   = ren;
        ramWEN   = wen;
        ramaddr  = addr;
        ramstore = store;
        check({tag, ":free"}, 32'(ramstate), ST_FREE);
        for (int i = 0; i < int'(LAT); i++) begin
            @(negedge CLK);
            check({tag, ":busy"}, 32'(ramstate), ST_BUSY);
            check({tag, ":busy_load"}, ramload, 32'h0);
        end
        @(negedge CLK);
        check({tag, ":access"}, 32'(ramstate), ST_ACCESS);
        if (chk_load) begin
            check({tag, ":load"}, ramload, exp_load);
        end
        if (drop) begin
            ramREN = 1'b0;
            ramWEN = 1'b0;
            @(negedge CLK);
            check({tag, ":after"}, 32'(ramstate), ST_FREE);
            check({tag, ":after_load"}, ramload, 32'h0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        nRST     = 1'b0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'h0;
        ramstore = 32'h0;
        ldWEN    = 1'b0;
        ldaddr   = '0;
        lddata   = 32'h0;

        // Reset state
        @(negedge CLK);
        check("rst_state", 32'(ramstate), ST_FREE);
        check("rst_load", ramload, 32'h0);
        nRST = 1'b1;
        @(negedge CLK);

        // Preloads used throughout
        preload(14'd0,  32'h0000_C0DE);
        preload(14'd4,  32'hDEAD_BEEF);
        preload(14'd5,  32'h5555_0014);
        preload(14'd16, 32'hA0A0_0040);
        preload(14'd17, 32'hB1B1_0044);
        preload(14'd12, 32'h0C0C_0C0C);
        peek("peek4", 14'd4, 32'hDEAD_BEEF);

        // Basic read with full latency window
        run_req("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1);

        // Write then read back
        run_req("wr20", 1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 32'h0, 1'b1);
        run_req("rd20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h1234_5678, 1'b1);
        peek("peek8", 14'd8, 32'h1234_5678);

        // Back-to-back words: each pays its own BUSY window
        run_req("rd40", 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'hA0A0_0040, 1'b0);
        @(negedge CLK);
        run_req("rd44", 1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 32'hB1B1_0044, 1'b1);

        // Address change in the second BUSY cycle restarts the countdown
        ramREN  = 1'b1;
        ramaddr = 32'h10;
        check("chg:free", 32'(ramstate), ST_FREE);
        @(negedge CLK);
        check("chg:busy1", 32'(ramstate), ST_BUSY);
        @(negedge CLK);
        check("chg:busy2", 32'(ramstate), ST_BUSY);
        ramaddr = 32'h14;
        for (int i = 0; i < int'(LAT); i++) begin
            @(negedge CLK);
            check("chg:restart_busy", 32'(ramstate), ST_BUSY);
        end
        @(negedge CLK);
        check("chg:access", 32'(ramstate), ST_ACCESS);
        check("chg:load", ramload, 32'h5555_0014);
        ramREN = 1'b0;
        @(negedge CLK);
        check("chg:after", 32'(ramstate), ST_FREE);

        // Both strobes high: ERROR while held, no write
        ramREN   = 1'b1;
        ramWEN   = 1'b1;
        ramaddr  = 32'h10;
        ramstore = 32'hBAD0_BAD0;
        check("both:free", 32'(ramstate), ST_FREE);
        @(negedge CLK);
        check("both:err1", 32'(ramstate), ST_ERROR);
        check("both:load", ramload, 32'h0);
        @(negedge CLK);
        check("both:err2", 32'(ramstate), ST_ERROR);
        ramREN = 1'b0;
        ramWEN = 1'b0;
        @(negedge CLK);
        check("both:after", 32'(ramstate), ST_FREE);
        peek("both:mem4", 14'd4, 32'hDEAD_BEEF);

        // Out-of-range write: ERROR, aliased word untouched
        ramWEN   = 1'b1;
        ramaddr  = 32'h0010_0000;
        ramstore = 32'hBAD1_BAD1;
        check("oor:free", 32'(ramstate), ST_FREE);
        @(negedge CLK);
        check("oor:err1", 32'(ramstate), ST_ERROR);
        @(negedge CLK);
        check("oor:err2", 32'(ramstate), ST_ERROR);
        ramWEN = 1'b0;
        @(negedge CLK);
        check("oor:after", 32'(ramstate), ST_FREE);
        peek("oor:mem0", 14'd0, 32'h0000_C0DE);

        // Asynchronous reset during BUSY of a write discards it
        ramWEN   = 1'b1;
        ramaddr  = 32'h30;
        ramstore = 32'hFFFF_0000;
        check("rstw:free", 32'(ramstate), ST_FREE);
        @(negedge CLK);
        check("rstw:busy", 32'(ramstate), ST_BUSY);
        nRST = 1'b0;
        #1;
        check("rstw:async", 32'(ramstate), ST_FREE);
        ramWEN   = 1'b0;
        ramaddr  = 32'h0;
        ramstore = 32'h0;
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        peek("rstw:mem12", 14'd12, 32'h0C0C_0C0C);
        run_req("rd30", 1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 32'h0C0C_0C0C, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
